// File: rtl/pcie_vc_switch.sv
// pcie_vc_switch: class-steered virtual-channel FIFOs drained by a
// threshold-aware round-robin arbiter into one ready/valid egress register.
// A small control FSM owns threshold configuration; per-class egress counters
// are readable through a req/idx strobe interface while idle.
module pcie_vc_switch #(
   parameter int NUM_CH    = 4,
   parameter int DATA_W    = 12,
   parameter int DEPTH     = 8,
   parameter int CLASS_LSB = 8,
   parameter int CNT_W     = 8,
   parameter int TH_W      = $clog2(DEPTH) + 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      init,
   input  logic [TH_W-1:0]           umbral_L,
   input  logic [TH_W-1:0]           umbral_H,
   input  logic                      in_valid,
   input  logic [DATA_W-1:0]         in_data,
   output logic                      in_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   input  logic                      out_ready,
   output logic [NUM_CH-1:0]         empty,
   output logic [NUM_CH-1:0]         almost_full,
   output logic [NUM_CH-1:0]         almost_empty,
   input  logic                      req,
   input  logic [$clog2(NUM_CH)-1:0] idx,
   output logic [CNT_W-1:0]          data,
   output logic                      valid,
   output logic [2:0]                state,
   output logic                      idle,
   output logic                      error
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = PTR_W + 1;

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   mem_q    [NUM_CH][DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q [NUM_CH];
   logic [PTR_W-1:0]    rd_ptr_q [NUM_CH];
   logic [CW-1:0]       count_q  [NUM_CH];
   logic [CNT_W-1:0]    cnt_q    [NUM_CH];
   logic [TH_W-1:0]     th_l_q, th_h_q;
   logic [NUM_CH-1:0]   urgent_q, urgent_d;
   logic [CH_W-1:0]     rr_q;
   logic                out_valid_q;
   logic [DATA_W-1:0]   out_data_q;
   logic                rd_valid_q;
   logic [CNT_W-1:0]    rd_data_q;

   logic [NUM_CH-1:0]   ne, full, cand, push_vec, pop_vec;
   logic [CH_W-1:0]     in_cls, out_cls, grant, arb_idx;
   logic                arb_found, any_ne, any_urg, active, push, load;

   assign in_cls  = in_data[CLASS_LSB +: CH_W];
   assign out_cls = out_data_q[CLASS_LSB +: CH_W];
   assign active  = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
   assign any_ne  = |ne;
   assign in_ready = active && !full[in_cls];
   assign push    = in_valid && in_ready;
   assign load    = active && (!out_valid_q || out_ready) && any_ne;

   // Occupancy flags and the hysteresis update of the urgent flags.
   always_comb begin
      ne           = '0;
      full         = '0;
      almost_full  = '0;
      almost_empty = '0;
      urgent_d     = urgent_q;
      for (int i = 0; i < NUM_CH; i++) begin
         ne[i]           = (count_q[i] != '0);
         full[i]         = (int'(count_q[i]) == DEPTH);
         almost_full[i]  = (int'(count_q[i]) >= int'(th_h_q));
         almost_empty[i] = (int'(count_q[i]) <= int'(th_l_q));
         if (almost_full[i])
            urgent_d[i] = 1'b1;
         else if (almost_empty[i])
            urgent_d[i] = 1'b0;
      end
   end

   assign empty = ~ne;

   // Round-robin search from last grant + 1, restricted to urgent VCs when any is pending.
   always_comb begin
      any_urg   = |(urgent_d & ne);
      cand      = any_urg ? (urgent_d & ne) : ne;
      grant     = rr_q;
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         arb_idx = CH_W'((int'(rr_q) + k) % NUM_CH);
         if (!arb_found && cand[arb_idx]) begin
            grant     = arb_idx;
            arb_found = 1'b1;
         end
      end
   end

   // Per-channel push/pop decode.
   always_comb begin
      push_vec = '0;
      pop_vec  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         push_vec[i] = push && (in_cls == CH_W'(i));
         pop_vec[i]  = load && (grant == CH_W'(i));
      end
   end

   // FIFO pointers and occupancy; reset discards all stored words at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            count_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (push_vec[i])
               wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
            if (pop_vec[i])
               rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
            if (push_vec[i] && !pop_vec[i])
               count_q[i] <= count_q[i] + CW'(1);
            else if (!push_vec[i] && pop_vec[i])
               count_q[i] <= count_q[i] - CW'(1);
         end
      end
   end

   // FIFO storage; contents are only meaningful under the occupancy counts.
   always_ff @(posedge clk) begin
      if (push)
         mem_q[in_cls][wr_ptr_q[in_cls]] <= in_data;
   end

   // Egress register, arbiter pointer and urgent flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         rr_q        <= '0;
         urgent_q    <= '0;
      end else begin
         urgent_q <= urgent_d;
         if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mem_q[grant][rd_ptr_q[grant]];
            rr_q        <= grant;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // Threshold latch: follows the inputs for as long as the FSM sits in INIT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th_l_q <= '0;
         th_h_q <= TH_W'(DEPTH);
      end else if (state_q == ST_INIT) begin
         th_l_q <= umbral_L;
         th_h_q <= umbral_H;
      end
   end

   // Control FSM next-state; pending traffic in IDLE takes priority over init.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET:  state_d = ST_INIT;
         ST_INIT: begin
            if (!init) begin
               if ((umbral_L >= umbral_H) || (int'(umbral_H) > DEPTH))
                  state_d = ST_ERROR;
               else
                  state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (any_ne || out_valid_q)
               state_d = ST_ACTIVE;
            else if (init)
               state_d = ST_INIT;
         end
         ST_ACTIVE: begin
            if (!any_ne && !out_valid_q)
               state_d = ST_IDLE;
         end
         ST_ERROR:  state_d = ST_ERROR;
         default:   state_d = ST_RESET;
      endcase
   end

   // Control FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_q <= ST_RESET;
      else
         state_q <= state_d;
   end

   // Per-class egress counters, cleared on every entry into INIT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++)
            cnt_q[i] <= '0;
      end else if ((state_d == ST_INIT) && (state_q != ST_INIT)) begin
         for (int i = 0; i < NUM_CH; i++)
            cnt_q[i] <= '0;
      end else if (out_valid_q && out_ready) begin
         cnt_q[out_cls] <= cnt_q[out_cls] + CNT_W'(1);
      end
   end

   // Counter read port: one-cycle strobe, data holds between reads.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else if ((state_q == ST_IDLE) && req) begin
         rd_valid_q <= 1'b1;
         rd_data_q  <= cnt_q[idx];
      end else begin
         rd_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign data      = rd_data_q;
   assign valid     = rd_valid_q;
   assign state     = state_q;
   assign idle      = (state_q == ST_IDLE);
   assign error     = (state_q == ST_ERROR);

endmodule

// File: tb/tb_pcie_vc_switch.sv
// Bench for pcie_vc_switch: configuration table plus hand-written traffic
// sequences, with an egress scoreboard fed by the stimulus code.
module tb_pcie_vc_switch;

   localparam int DATA_W = 12;

   logic              clk = 1'b0;
   logic              reset;
   logic              init;
   logic [3:0]        umbral_L, umbral_H;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic [3:0]        empty, almost_full, almost_empty;
   logic              req;
   logic [1:0]        idx;
   logic [7:0]        data;
   logic              valid;
   logic [2:0]        state;
   logic              idle, error;

   pcie_vc_switch dut (
      .clk(clk), .reset(reset), .init(init), .umbral_L(umbral_L), .umbral_H(umbral_H),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
      .req(req), .idx(idx), .data(data), .valid(valid),
      .state(state), .idle(idle), .error(error)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] mon_exp;

   typedef struct {
      logic [3:0] l;
      logic [3:0] h;
      logic [2:0] exp_state;
      logic       exp_err;
      logic       exp_rdy;
   } cfg_vec_t;
   cfg_vec_t cfg_tab[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push1(input logic [DATA_W-1:0] w);
      in_valid = 1'b1;
      in_data  = w;
      step(1);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input int limit);
      int n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         step(1);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout actual=%0d words pending required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic apply_reset();
      reset = 1'b0; init = 1'b0; req = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("rst_state",        32'(state),        32'd0);
      chk("rst_in_ready",     32'(in_ready),     32'd0);
      chk("rst_out_valid",    32'(out_valid),    32'd0);
      chk("rst_out_data",     32'(out_data),     32'd0);
      chk("rst_data",         32'(data),         32'd0);
      chk("rst_valid",        32'(valid),        32'd0);
      chk("rst_error",        32'(error),        32'd0);
      chk("rst_idle",         32'(idle),         32'd0);
      chk("rst_empty",        32'(empty),        32'hF);
      chk("rst_almost_full",  32'(almost_full),  32'h0);
      chk("rst_almost_empty", 32'(almost_empty), 32'hF);
      exp_q.delete();
      step(1);
      reset = 1'b1;
   endtask

   task automatic configure(input logic [3:0] l, input logic [3:0] h);
      init = 1'b1; umbral_L = l; umbral_H = h;
      step(1);
      chk("init_entry_state", 32'(state), 32'd1);
      step(1);
      init = 1'b0;
      step(1);
   endtask

   task automatic read_cnt(input logic [1:0] sel, input logic [7:0] exp, input string name);
      idx = sel; req = 1'b1;
      step(1);
      req = 1'b0;
      chk({name, "_valid"}, 32'(valid), 32'd1);
      chk(name,             32'(data),  32'(exp));
   endtask

   // Egress scoreboard: every handshake must match the next expected word.
   always @(negedge clk) begin
      if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL egress_unexpected actual=0x%0h required=none", out_data);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("egress_word", 32'(out_data), 32'(mon_exp));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cfg_tab[0] = '{4'd6, 4'd3, 3'd4, 1'b1, 1'b0};
      cfg_tab[1] = '{4'd3, 4'd3, 3'd4, 1'b1, 1'b0};
      cfg_tab[2] = '{4'd2, 4'd9, 3'd4, 1'b1, 1'b0};
      cfg_tab[3] = '{4'd0, 4'd8, 3'd2, 1'b0, 1'b1};
      cfg_tab[4] = '{4'd2, 4'd6, 3'd2, 1'b0, 1'b1};

      reset = 1'b1; init = 1'b0; umbral_L = '0; umbral_H = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0; req = 1'b0; idx = '0;
      #2;

      // configuration table: each entry from a fresh reset
      for (int t = 0; t < 5; t++) begin
         apply_reset();
         chk("post_release_state", 32'(state), 32'd0);
         in_data = 12'h000;
         configure(cfg_tab[t].l, cfg_tab[t].h);
         chk("cfg_state",    32'(state),    32'(cfg_tab[t].exp_state));
         chk("cfg_error",    32'(error),    32'(cfg_tab[t].exp_err));
         chk("cfg_in_ready", 32'(in_ready), 32'(cfg_tab[t].exp_rdy));
         chk("cfg_idle",     32'(idle),     32'(!cfg_tab[t].exp_err));
         if (cfg_tab[t].exp_err) begin
            init = 1'b1;
            step(3);
            init = 1'b0;
            chk("err_sticky_state", 32'(state),    32'd4);
            chk("err_in_ready",     32'(in_ready), 32'd0);
         end
      end

      // steering with egress stalled
      out_ready = 1'b0;
      push1(12'h100);
      chk("steer_empty_first", 32'(empty), 32'b1101);
      push1(12'h200);
      chk("steer_out_valid", 32'(out_valid), 32'd1);
      chk("steer_out_data",  32'(out_data),  32'h100);
      push1(12'h300);
      push1(12'h000);
      chk("steer_empty_all", 32'(empty), 32'b0010);
      step(3);
      chk("steer_hold_data",  32'(out_data),  32'h100);
      chk("steer_hold_valid", 32'(out_valid), 32'd1);
      chk("steer_active",     32'(state),     32'd3);
      exp_q.push_back(12'h100); exp_q.push_back(12'h200);
      exp_q.push_back(12'h300); exp_q.push_back(12'h000);
      out_ready = 1'b1;
      wait_drain(20);
      step(1);
      chk("steer_drain_valid", 32'(out_valid), 32'd0);
      chk("steer_idle",        32'(state),     32'd2);

      // round-robin: two words per VC, first word is class 1
      out_ready = 1'b0;
      push1(12'h101); push1(12'h001); push1(12'h201); push1(12'h301);
      push1(12'h002); push1(12'h102); push1(12'h202); push1(12'h302);
      exp_q.push_back(12'h101); exp_q.push_back(12'h201);
      exp_q.push_back(12'h301); exp_q.push_back(12'h001);
      exp_q.push_back(12'h102); exp_q.push_back(12'h202);
      exp_q.push_back(12'h302); exp_q.push_back(12'h002);
      out_ready = 1'b1;
      wait_drain(30);
      step(1);
      chk("rr_back_to_idle", 32'(state), 32'd2);

      // hysteresis: VC2 at 6 words, VC1 at 3
      out_ready = 1'b0;
      for (int i = 1; i <= 7; i++) push1(12'h200 | 12'(i));
      push1(12'h111); push1(12'h112); push1(12'h113);
      chk("hyst_almost_full",  32'(almost_full),  32'b0100);
      chk("hyst_almost_empty", 32'(almost_empty), 32'b1001);
      chk("hyst_empty",        32'(empty),        32'b1001);
      exp_q.push_back(12'h201); exp_q.push_back(12'h202); exp_q.push_back(12'h203);
      exp_q.push_back(12'h204); exp_q.push_back(12'h205); exp_q.push_back(12'h111);
      exp_q.push_back(12'h206); exp_q.push_back(12'h112); exp_q.push_back(12'h207);
      exp_q.push_back(12'h113);
      out_ready = 1'b1;
      step(1);
      chk("hyst_af_drop_at5", 32'(almost_full), 32'b0000);
      wait_drain(30);
      step(1);

      // full VC3 and backpressure
      out_ready = 1'b0;
      push1(12'h000);
      for (int i = 1; i <= 8; i++) push1(12'h300 | 12'(i));
      in_data = 12'h309;
      #1;
      chk("full_in_ready_c3", 32'(in_ready), 32'd0);
      in_data = 12'h000;
      #1;
      chk("full_in_ready_c0", 32'(in_ready), 32'd1);
      chk("full_almost_full", 32'(almost_full), 32'b1000);
      chk("full_empty",       32'(empty),       32'b0111);
      in_data = 12'h309; in_valid = 1'b1;
      step(2);
      chk("full_still_blocked", 32'(in_ready), 32'd0);
      exp_q.push_back(12'h000);
      for (int i = 1; i <= 9; i++) exp_q.push_back(12'h300 | 12'(i));
      out_ready = 1'b1;
      step(1);
      chk("full_ready_after_pop", 32'(in_ready), 32'd1);
      step(1);
      in_valid = 1'b0;
      wait_drain(30);
      step(2);

      // counters since last INIT: class3 = 12, class2 = 10
      read_cnt(2'd3, 8'd12, "cnt_class3");
      step(1);
      chk("cnt_strobe_drop", 32'(valid), 32'd0);
      chk("cnt_data_hold",   32'(data),  32'd12);
      read_cnt(2'd2, 8'd10, "cnt_class2");

      // reset in the middle of a transfer
      out_ready = 1'b0;
      push1(12'h211); push1(12'h212); push1(12'h213);
      apply_reset();
      configure(4'd2, 4'd6);
      chk("midrst_empty",     32'(empty),     32'hF);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_idle",      32'(state),     32'd2);

      // 257 class-1 words: counter wraps to 1
      out_ready = 1'b1;
      for (int i = 0; i < 257; i++) begin
         exp_q.push_back(12'h100 | 12'(i & 255));
         if (i == 100) begin
            req = 1'b1; idx = 2'd1;
         end
         push1(12'h100 | 12'(i & 255));
         if (i == 100) begin
            req = 1'b0;
            chk("cnt_req_active_valid", 32'(valid), 32'd0);
            chk("cnt_req_active_state", 32'(state), 32'd3);
         end
      end
      wait_drain(20);
      step(2);
      read_cnt(2'd1, 8'd1, "cnt_wrap_class1");
      read_cnt(2'd0, 8'd0, "cnt_class0_zero");

      // re-entering INIT clears the counters
      configure(4'd2, 4'd6);
      chk("reinit_idle", 32'(state), 32'd2);
      read_cnt(2'd1, 8'd0, "cnt_cleared_by_init");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
